// File: rtl/mc_dp_pkg.sv
// Shared encodings for the multicycle datapath: ALU ops, operand/result selects,
// immediate formats and the iterative multiplier state.
package mc_dp_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;

  localparam logic [1:0] SRCA_A      = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_STEP = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_MUL    = 2'b11;

  localparam logic [1:0] IMM_B8  = 2'b00;
  localparam logic [1:0] IMM_B12 = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_RUN  = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/mc_iter_mul.sv
// Shift-add multiplier retiring MUL_BPC multiplier bits per cycle; done pulses WIDTH/MUL_BPC+1 cycles after start.
// MUL_EARLY_EXIT_EN: leave RUN as soon as the remaining multiplier bits are zero (same result, shorter latency).
module mc_iter_mul #(
  parameter int WIDTH   = 32,
  parameter int MUL_BPC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  import mc_dp_pkg::*;

  localparam int STEPS = WIDTH / MUL_BPC;
  localparam int CW    = $clog2(STEPS);

  mul_state_t       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mplier_next;
  logic [CW-1:0]    cnt;
  logic             last;

  always_comb begin
    acc_next = acc;
    for (int i = 0; i < MUL_BPC; i++) begin
      if (mplier[i]) acc_next = acc_next + (mcand << i);
    end
  end

  assign mplier_next = mplier >> MUL_BPC;

`ifdef MUL_EARLY_EXIT_EN
  assign last = (cnt == CW'(STEPS - 1)) || (mplier_next == '0);
`else
  assign last = (cnt == CW'(STEPS - 1));
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= MUL_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= '0;
            cnt    <= '0;
            state  <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << MUL_BPC;
          mplier <= mplier_next;
          cnt    <= cnt + 1'b1;
          // result is a separate register so it stays stable while the next product accumulates
          if (last) begin
            result <= acc_next;
            state  <= MUL_DONE;
          end
        end
        MUL_DONE: state <= MUL_IDLE;
        default:  state <= MUL_IDLE;
      endcase
    end
  end

  assign busy = (state == MUL_RUN);
  assign done = (state == MUL_DONE);

endmodule

// File: rtl/mc_datapath_mul.sv
// Multicycle datapath (PC, IR, Data/A/B/ALUOut, regfile, extender, ALU) plus iterative multiplier on ResultSrc=11.
// Optional MUL_EARLY_EXIT_EN shortens multiplier latency for small multipliers; results are unchanged.
module mc_datapath_mul #(
  parameter int WIDTH   = 32,
  parameter int PC_STEP = 4,
  parameter int MUL_BPC = 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] Adr,
  output logic [WIDTH-1:0] WriteData,
  input  logic [WIDTH-1:0] ReadData,
  output logic [31:0]      Instr,
  output logic [3:0]       ALUFlags,
  input  logic             PCWrite,
  input  logic             RegWrite,
  input  logic             IRWrite,
  input  logic             AdrSrc,
  input  logic [1:0]       RegSrc,
  input  logic [1:0]       ALUSrcA,
  input  logic [1:0]       ALUSrcB,
  input  logic [1:0]       ResultSrc,
  input  logic [1:0]       ImmSrc,
  input  logic [2:0]       ALUControl,
  input  logic             MulStart,
  output logic             MulBusy,
  output logic             MulDone
);
  import mc_dp_pkg::*;

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [WIDTH-1:0] ext_imm;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] mul_result;
  logic [3:0]       ra1;
  logic [3:0]       ra2;
  logic             carry;
  logic             ovf;
  logic [WIDTH-1:0] rf [0:15];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= '0;
      Instr   <= '0;
      data    <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
    end else begin
      if (PCWrite) pc <= result;
      if (IRWrite) Instr <= ReadData[31:0];
      data    <= ReadData;
      a_reg   <= rd1;
      b_reg   <= rd2;
      alu_out <= alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (RegWrite) rf[Instr[15:12]] <= result;
  end

  assign ra1 = RegSrc[0] ? 4'd15 : Instr[19:16];
  assign ra2 = RegSrc[1] ? Instr[15:12] : Instr[3:0];
  // R15 is not a storage location: reads see the current Result
  assign rd1 = (ra1 == 4'd15) ? result : rf[ra1];
  assign rd2 = (ra2 == 4'd15) ? result : rf[ra2];

  always_comb begin
    case (ImmSrc)
      IMM_B8:  ext_imm = {{(WIDTH-8){1'b0}}, Instr[7:0]};
      IMM_B12: ext_imm = {{(WIDTH-12){1'b0}}, Instr[11:0]};
      IMM_BR:  ext_imm = {{(WIDTH-26){Instr[23]}}, Instr[23:0], 2'b00};
      default: ext_imm = '0;
    endcase
  end

  always_comb begin
    case (ALUSrcA)
      SRCA_A:      src_a = a_reg;
      SRCA_PC:     src_a = pc;
      SRCA_ALUOUT: src_a = alu_out;
      default:     src_a = '0;
    endcase
    case (ALUSrcB)
      SRCB_WD:   src_b = b_reg;
      SRCB_IMM:  src_b = ext_imm;
      SRCB_STEP: src_b = WIDTH'(PC_STEP);
      default:   src_b = '0;
    endcase
  end

  always_comb begin
    alu_result = '0;
    carry      = 1'b0;
    ovf        = 1'b0;
    case (ALUControl)
      ALU_ADD: begin
        {carry, alu_result} = {1'b0, src_a} + {1'b0, src_b};
        ovf = (src_a[MSB] == src_b[MSB]) && (alu_result[MSB] != src_a[MSB]);
      end
      ALU_SUB: begin
        // carry set means no borrow
        {carry, alu_result} = {1'b0, src_a} + {1'b0, ~src_b} + (WIDTH+1)'(1);
        ovf = (src_a[MSB] != src_b[MSB]) && (alu_result[MSB] != src_a[MSB]);
      end
      ALU_AND: alu_result = src_a & src_b;
      ALU_ORR: alu_result = src_a | src_b;
      ALU_EOR: alu_result = src_a ^ src_b;
      ALU_MOV: alu_result = src_b;
      default: alu_result = '0;
    endcase
  end

  assign ALUFlags = {alu_result[MSB], (alu_result == '0), carry, ovf};

  always_comb begin
    case (ResultSrc)
      RES_ALUOUT: result = alu_out;
      RES_DATA:   result = data;
      RES_ALU:    result = alu_result;
      RES_MUL:    result = mul_result;
      default:    result = '0;
    endcase
  end

  assign Adr       = AdrSrc ? result : pc;
  assign WriteData = b_reg;

  mc_iter_mul #(
    .WIDTH   (WIDTH),
    .MUL_BPC (MUL_BPC)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (MulStart),
    .op_a   (a_reg),
    .op_b   (b_reg),
    .busy   (MulBusy),
    .done   (MulDone),
    .result (mul_result)
  );

endmodule

// File: tb/tb_mc_datapath_mul.sv
// Bench for mc_datapath_mul: fetch, ALU ops/flags, load path, multiplier with a result scoreboard, reset mid-run.
module tb_mc_datapath_mul;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Adr, WriteData, ReadData, Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]  ALUControl;
  logic        MulStart, MulBusy, MulDone;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  mc_datapath_mul #(.WIDTH(32), .PC_STEP(4), .MUL_BPC(1)) dut (
    .clk(clk), .reset(rst_n), .Adr(Adr), .WriteData(WriteData), .ReadData(ReadData),
    .Instr(Instr), .ALUFlags(ALUFlags), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .MulStart(MulStart), .MulBusy(MulBusy), .MulDone(MulDone)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctrl();
    PCWrite = 0; RegWrite = 0; IRWrite = 0; AdrSrc = 0; RegSrc = 2'b00;
    ALUSrcA = 2'b00; ALUSrcB = 2'b00; ResultSrc = 2'b00; ImmSrc = 2'b00;
    ALUControl = 3'b000; MulStart = 0;
  endtask

  task automatic load_ir(input logic [31:0] ins);
    ReadData = ins; IRWrite = 1;
    tick();
    IRWrite = 0;
  endtask

  task automatic write_reg(input logic [3:0] rd, input logic [31:0] val);
    load_ir({16'h0, rd, 12'h0});
    ReadData = val;
    tick();
    ResultSrc = 2'b01; RegWrite = 1;
    tick();
    RegWrite = 0; ResultSrc = 2'b00;
  endtask

  task automatic set_ab(input logic [3:0] rn, input logic [3:0] rm);
    load_ir({12'h0, rn, 12'h0, rm});
    tick();
  endtask

  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input bit poke);
    int lat;
    int busy_cnt;
    logic [31:0] exp;
    write_reg(4'd1, a);
    write_reg(4'd2, b);
    set_ab(4'd1, 4'd2);
    ResultSrc = 2'b11; AdrSrc = 1;
    MulStart = 1;
    sb_q.push_back(a * b);
    tick();
    MulStart = 0;
    lat = 1; busy_cnt = 0;
    while (!MulDone && lat <= 200) begin
      if (MulBusy) busy_cnt++;
      MulStart = poke && (lat == 4);
      tick();
      lat++;
    end
    MulStart = 0;
    chk({tag, "_done_seen"}, {31'h0, MulDone}, 32'h1);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_cycles"}, busy_cnt, exp_lat - 1);
    chk({tag, "_busy_at_done"}, {31'h0, MulBusy}, 32'h0);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
    chk({tag, "_result"}, Adr, exp);
    tick();
    chk({tag, "_done_pulse"}, {31'h0, MulDone}, 32'h0);
    chk({tag, "_result_held"}, Adr, exp);
    idle_ctrl();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    logic [31:0] ra, rb;
    logic [2:0]  op_tab  [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [31:0] res_tab [8] = '{32'h8000_0000, 32'h7FFF_FFFE, 32'h1, 32'h7FFF_FFFF,
                                 32'h7FFF_FFFE, 32'h1, 32'h0, 32'h0};
    logic [3:0]  flg_tab [8] = '{4'b1001, 4'b0010, 4'b0000, 4'b0000,
                                 4'b0000, 4'b0000, 4'b0100, 4'b0100};

    idle_ctrl();
    ReadData = 32'h0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_adr", Adr, 32'h0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_writedata", WriteData, 32'h0);
    chk("rst_busy", {31'h0, MulBusy}, 32'h0);
    chk("rst_done", {31'h0, MulDone}, 32'h0);
    rst_n = 1;
    tick();

    // fetch
    ReadData = 32'hE280_1005; IRWrite = 1; ALUSrcA = 2'b01; ALUSrcB = 2'b10;
    ALUControl = 3'b000; ResultSrc = 2'b10; PCWrite = 1;
    #1;
    chk("fetch_adr_before", Adr, 32'h0);
    tick();
    idle_ctrl();
    chk("fetch_instr", Instr, 32'hE280_1005);
    chk("fetch_pc", Adr, 32'h4);

    // ALU ops against A=0x7FFFFFFF, ExtImm=1
    write_reg(4'd3, 32'h7FFF_FFFF);
    set_ab(4'd3, 4'd1);
    ALUSrcA = 2'b00; ALUSrcB = 2'b01; ImmSrc = 2'b00; AdrSrc = 1; ResultSrc = 2'b10;
    for (int i = 0; i < 8; i++) begin
      ALUControl = op_tab[i];
      #1;
      chk($sformatf("alu_res_op%0d", i), Adr, res_tab[i]);
      chk($sformatf("alu_nzcv_op%0d", i), {28'h0, ALUFlags}, {28'h0, flg_tab[i]});
    end
    ALUControl = 3'b101; ImmSrc = 2'b10;
    #1;
    chk("imm_branch", Adr, 32'h000C_0004);
    ImmSrc = 2'b01;
    #1;
    chk("imm_12", Adr, 32'h1);
    ImmSrc = 2'b11;
    #1;
    chk("imm_zero", Adr, 32'h0);
    ImmSrc = 2'b00; ALUControl = 3'b000;
    tick();
    ResultSrc = 2'b00;
    #1;
    chk("aluout_adr", Adr, 32'h8000_0000);
    idle_ctrl();

    // SUB 5-5
    write_reg(4'd4, 32'd5);
    set_ab(4'd4, 4'd5);
    ALUSrcB = 2'b01; ALUControl = 3'b001; ResultSrc = 2'b10; AdrSrc = 1;
    #1;
    chk("sub_res", Adr, 32'h0);
    chk("sub_nzcv", {28'h0, ALUFlags}, 32'h6);
    idle_ctrl();

    // load path into a register, read back through B
    write_reg(4'd6, 32'h0000_1234);
    set_ab(4'd0, 4'd6);
    chk("load_rd", WriteData, 32'h0000_1234);

    // multiplier
`ifdef MUL_EARLY_EXIT_EN
    run_mul("mul_7x6", 32'd7, 32'd6, 4, 0);
    run_mul("mul_ovf", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1);
    run_mul("mul_3x2", 32'd3, 32'd2, 3, 0);
    run_mul("mul_zero", 32'd12345, 32'd0, 2, 0);
`else
    run_mul("mul_7x6", 32'd7, 32'd6, 33, 0);
    run_mul("mul_ovf", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1);
    run_mul("mul_3x2", 32'd3, 32'd2, 33, 0);
    run_mul("mul_zero", 32'd12345, 32'd0, 33, 0);
`endif
    for (int k = 0; k < 2; k++) begin
      ra = $urandom;
      rb = $urandom | 32'h8000_0000;
      run_mul($sformatf("mul_rand%0d", k), ra, rb, 33, 0);
    end

    // reset in the middle of a run
    write_reg(4'd1, 32'd7);
    write_reg(4'd2, 32'd6);
    set_ab(4'd1, 4'd2);
    MulStart = 1;
    tick();
    MulStart = 0;
    repeat (5) tick();
    chk("midrun_busy", {31'h0, MulBusy}, 32'h1);
    rst_n = 0;
    #1;
    chk("midrun_rst_busy", {31'h0, MulBusy}, 32'h0);
    chk("midrun_rst_done", {31'h0, MulDone}, 32'h0);
    chk("midrun_rst_instr", Instr, 32'h0);
    chk("midrun_rst_wd", WriteData, 32'h0);
    chk("midrun_rst_adr", Adr, 32'h0);
    tick();
    rst_n = 1;
    tick();
    chk("post_rst_pc", Adr, 32'h0);
    AdrSrc = 1; ResultSrc = 2'b11;
    #1;
    chk("post_rst_mulres", Adr, 32'h0);
    cnt = 0;
    repeat (40) begin
      if (MulDone || MulBusy) cnt++;
      tick();
    end
    chk("post_rst_no_mul", cnt, 0);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
